// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one full-adder cell with a registered carry.
// Optional two's-complement overflow output: define SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_nxt;

  assign fa_a  = sh_a[0];
  assign fa_b  = sh_b[0];
  assign fa_ci = c;

  always_comb begin
    fa_s  = fa_a ^ fa_b ^ fa_ci;
    fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
  end

  // new sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
  assign res_nxt = (res >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      res     <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sh_a  <= a_in;
            sh_b  <= b_in;
            c     <= cin;
            res   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_nxt;
          c    <= fa_co;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_out <= res_nxt;
            cout    <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= c ^ fa_co;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8).
// Cycle-level model: cycles since accept decide ready/busy/done.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a_in(a),
    .b_in(b),
    .cin(cin),
    .ready(ready),
    .busy(busy),
    .done(done),
    .sum_out(sum_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // model: since=0 idle, 1..8 running, 9 done cycle
  int         since = 0;
  bit         mvalid = 0;
  logic [8:0] pend;
  logic       pend_ovf;
  logic [7:0] exp_sum;
  logic       exp_cout;
  logic       exp_ovf;

  always @(posedge clk) begin
    if (rst) begin
      since    = 0;
      exp_sum  = 8'h00;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      mvalid   = 1;
    end else if (since == 0) begin
      if (start) begin
        pend     = 9'(a) + 9'(b) + 9'(cin);
        pend_ovf = ((a[7] == b[7]) && (pend[7] != a[7]));
        since    = 1;
      end
    end else if (since == 9) begin
      since = 0;
    end else begin
      since++;
      if (since == 9) begin
        exp_sum  = pend[7:0];
        exp_cout = pend[8];
        exp_ovf  = pend_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ready", 32'(ready), 32'(since == 0));
      check("busy", 32'(busy), 32'(since >= 1 && since <= 8));
      check("done", 32'(done), 32'(since == 9));
      check("sum_out", 32'(sum_out), 32'(exp_sum));
      check("cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    end
  end

  // es/ec < 0: rely on the model only
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input int es, input int ec);
    int n;
    int bc;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bc = 0;
    while (!done && n < 30) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd9);
    check("busy_cycles", 32'(bc), 32'd8);
    if (es >= 0) begin
      check("sum_lit", 32'(sum_out), 32'(es));
      check("model_sum_lit", 32'(exp_sum), 32'(es));
    end
    if (ec >= 0) check("cout_lit", 32'(cout), 32'(ec));
  endtask

  initial begin
    int s;
    int dn;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("ready_after_rst", 32'(ready), 32'd1);
    check("sum_after_rst", 32'(sum_out), 32'd0);

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1);
    run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1);
    run_op(8'h3C, 8'h12, 1'b0, 8'h4E, 0);

    for (int i = 0; i < 8; i++) begin
      s = i[0] + i[1] + i[2];
      run_op({7'd0, i[0]}, {7'd0, i[1]}, i[2], s, 0);
    end

    // second start during RUN must be ignored
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin
        dn++;
        check("ignored_start_sum", 32'(sum_out), 32'h30);
      end
    end
    check("one_done", 32'(dn), 32'd1);

    // reset in the middle of RUN
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 0);

`ifdef SERIAL_ADDER_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 0);
    check("ovf_7f", 32'(ovf), 32'd1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1);
    check("ovf_80", 32'(ovf), 32'd1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1);
    check("ovf_ff", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 30; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), -1, -1);

    // free-running random starts: back-to-back and ignored requests
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      start = ($urandom_range(0, 2) != 0);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around a single full-adder cell with a registered carry.
- Loads two WIDTH-bit operands plus a carry-in on a start handshake.
- Processes one bit per clock, LSB first, and presents the sum and carry-out with a one-cycle done pulse.
- Sits directly above the full-adder cell. It drives the cell's a/b/cin each cycle and consumes its sum/cout.
- Serves as the area-minimal alternative to the ripple-carry adder in the adder library.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
ready  output  1  high in IDLE; start accepted only then
busy  output  1  high in RUN
done  output  1  one-cycle pulse; sum_out/cout valid
sum_out  output  WIDTH  result; holds until next accepted start
cout  output  1  final carry-out; holds until next accepted start

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum_out=0, cout=0. Internal shift registers, carry flop and bit counter are all 0.
- Reset mid-RUN aborts the operation. No done is issued and outputs return to their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - capture a_in/b_in into shift registers A/B and cin into the carry flop;
  - counter<=0; go to RUN.
- IDLE, start=0: hold state and outputs.
- RUN, each edge:
  - s = A[0]^B[0]^c; c <= maj(A[0],B[0],c);
  - A, B shift right by 1; s shifts into result register MSB, shifting right;
  - counter++.
- RUN exit: at the edge where counter==WIDTH-1, go to DONE. The result register then holds the full sum, which is copied to sum_out, and the final carry goes to cout.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH. Accept-to-accept throughput is WIDTH+2 cycles.
- start while RUN or DONE is ignored. Operands are not re-sampled and are not queued.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1). Unsigned; there is no saturation.
- Outputs are registered. sum_out/cout change only on the transition into DONE or on rst.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output port ovf (1 bit, reset 0), updated together with cout;
  - ovf = carry into MSB XOR carry out of MSB, i.e. the two's-complement overflow of the signed add;
  - requires one extra flop capturing the carry before the final bit.
- Undefined: no ovf port, no extra flop; behaviour otherwise identical.

Test Plan:
All scenarios use WIDTH=8.
1. rst=1 for 2 cycles, then start pulse with a=0x00, b=0x00, cin=0 -> ready=1 after reset; busy for 8 cycles; done 9 cycles after the accepting edge; sum_out=0x00, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1. Also a=0x5A, b=0xA5, cin=1 -> sum_out=0x00, cout=1. Also a=0x3C, b=0x12, cin=0 -> sum_out=0x4E, cout=0.
3. Exhaustive check against the full-adder truth table on bit 0: all 8 combinations of a[0], b[0], cin with the upper bits 0 -> sum_out[0] and sum_out[1] match the reference a+b+cin.
4. Start a=0x10, b=0x20; pulse start again mid-RUN with a=0xFF, b=0xFF -> second start ignored; sum_out=0x30; exactly one done pulse.
5. Start a=0xF0, b=0x0F; assert rst at the 4th RUN cycle -> next cycle ready=1, busy=0, sum_out=0, cout=0; no done pulse. A following start with a=0x01, b=0x01 -> sum_out=0x02.
6. With SERIAL_ADDER_OVF_EN defined:
   - a=0x7F, b=0x01 -> sum_out=0x80, cout=0, ovf=1;
   - a=0x80, b=0x80 -> sum_out=0x00, cout=1, ovf=1;
   - a=0xFF, b=0x01 -> ovf=0.
